// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO pair.
// The result is computed when the operation is accepted and held until the
// busy window expires, so the sequence only shapes timing.
// Optional MADD/MSUB accumulate ops are built only when MDU_MADD_EN is defined.
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_e      r_state;
  logic [3:0]  r_cnt;
  op_e         r_op;
  logic [63:0] r_res;
  logic        r_bzero;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  op_e         w_op;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_acc;
  logic        w_signed;
  logic [63:0] w_ea;
  logic [63:0] w_eb;
  logic [63:0] w_prod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_ma;
  logic [31:0] w_mb;
  logic [31:0] w_dvs;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [63:0] w_res;
  logic        w_issue;
  logic        w_accept;
  logic        w_mt;

  // Decode the incoming op and compute its 64-bit result.
  always_comb begin
    w_op     = op_e'(op);
    w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
    w_is_div = (w_op == OP_DIV)  || (w_op == OP_DIVU);
`ifdef MDU_MADD_EN
    w_is_acc = (w_op == OP_MADD) || (w_op == OP_MSUB);
`else
    w_is_acc = 1'b0;
`endif
    w_signed = (w_op != OP_MULTU) && (w_op != OP_DIVU);
    w_ea     = w_signed ? {{32{a[31]}}, a} : {32'd0, a};
    w_eb     = w_signed ? {{32{b[31]}}, b} : {32'd0, b};
    w_prod   = w_ea * w_eb;
    // Divide on magnitudes and fix signs afterwards; this makes
    // 0x80000000 / -1 wrap to 0x80000000 and keeps b==0 out of the divider.
    w_neg_a  = w_signed && a[31];
    w_neg_b  = w_signed && b[31];
    w_ma     = w_neg_a ? -a : a;
    w_mb     = w_neg_b ? -b : b;
    w_dvs    = (w_mb == 32'd0) ? 32'd1 : w_mb;
    w_q      = w_ma / w_dvs;
    w_r      = w_ma % w_dvs;
    w_quo    = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
    w_rem    = w_neg_a ? -w_r : w_r;
    w_res    = w_is_div ? {w_rem, w_quo} : w_prod;
    w_issue  = (r_state == S_IDLE) && start && !flush;
    w_accept = w_issue && (w_is_mul || w_is_div || w_is_acc);
    w_mt     = w_issue && ((w_op == OP_MTHI) || (w_op == OP_MTLO));
  end

  // IDLE/RUN sequencer with registered busy/done and HI/LO update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_res   <= '0;
      r_bzero <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= w_is_div ? DIV_LOAD : MUL_LOAD;
            r_op    <= w_op;
            r_res   <= w_res;
            r_bzero <= (b == 32'd0);
          end else if (w_mt) begin
            if (w_op == OP_MTHI) r_hi <= a;
            else                 r_lo <= a;
          end
        end
        S_RUN: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            case (r_op)
              OP_MULT, OP_MULTU: {r_hi, r_lo} <= r_res;
              OP_DIV, OP_DIVU: begin
                if (!r_bzero) {r_hi, r_lo} <= r_res;
              end
`ifdef MDU_MADD_EN
              OP_MADD: {r_hi, r_lo} <= {r_hi, r_lo} + r_res;
              OP_MSUB: {r_hi, r_lo} <= {r_hi, r_lo} - r_res;
`endif
              default: ;
            endcase
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .flush (flush),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one start for a single edge; returns at the sample point of cycle 1.
  task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                    input logic f);
    start = 1'b1; op = o; a = x; b = y; flush = f;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", busy, done);
    end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_hilo hi=%h lo=%h expected 0 0", hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    go(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    a = 32'h1234; b = 32'h5678;
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL mult_busy cyc=%0d busy=%b done=%b expected 1 0", i, busy, done);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mult_done busy=%b done=%b expected 0 1", busy, done);
    end
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      n_fail++; $display("FAIL mult_result hi=%h lo=%h expected ffffffff fffffffa", hi, lo);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL mult_done_pulse done=%b expected 0", done);
    end
  endtask

  task automatic test_div;
    go(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL div_busy cyc=%0d busy=%b done=%b expected 1 0", i, busy, done);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL div_done busy=%b done=%b expected 0 1", busy, done);
    end
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL div_result hi=%h lo=%h expected ffffffff fffffffd", hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_div_overflow;
    go(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'h80000000) begin
      n_fail++; $display("FAIL div_ovf done=%b hi=%h lo=%h expected 1 00000000 80000000", done, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_mt_divzero;
    go(3'd4, 32'h11, 32'd0, 1'b0);
    n_checks++;
    if (hi !== 32'h11 || lo !== 32'h80000000 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mthi hi=%h lo=%h busy=%b done=%b expected 11 80000000 0 0", hi, lo, busy, done);
    end
    go(3'd5, 32'h22, 32'd0, 1'b0);
    n_checks++;
    if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mtlo hi=%h lo=%h busy=%b done=%b expected 11 22 0 0", hi, lo, busy, done);
    end
    go(3'd3, 32'd5, 32'd0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL divz_busy cyc=%0d busy=%b done=%b expected 1 0", i, busy, done);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || hi !== 32'h11 || lo !== 32'h22) begin
      n_fail++; $display("FAIL divz_result done=%b hi=%h lo=%h expected 1 11 22", done, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    go(3'd1, 32'd2, 32'd3, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL ign_busy cyc=%0d busy=%b done=%b expected 1 0", i, busy, done);
      end
      if (i == 2) begin
        start = 1'b1; op = 3'd5; a = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd6) begin
      n_fail++; $display("FAIL ign_result done=%b hi=%h lo=%h expected 1 0 6", done, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    go(3'd0, 32'd5, 32'd5, 1'b1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_start busy=%b expected 0", busy);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL flush_idle cyc=%0d busy=%b done=%b expected 0 0", i, busy, done);
      end
      @(negedge clk);
    end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin
      n_fail++; $display("FAIL flush_hilo hi=%h lo=%h expected 0 6", hi, lo);
    end
    go(3'd1, 32'd4, 32'd5, 1'b0);
    flush = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL flush_run cyc=%0d busy=%b expected 1", i, busy);
      end
      @(negedge clk);
    end
    flush = 1'b0;
    n_checks++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd20) begin
      n_fail++; $display("FAIL flush_run_result done=%b hi=%h lo=%h expected 1 0 14", done, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    go(3'd1, 32'd3, 32'd3, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL b2b_busy cyc=%0d busy=%b done=%b expected 1 0", i, busy, done);
      end
      if (i == 5) begin
        start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd7;
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || lo !== 32'd9) begin
      n_fail++; $display("FAIL b2b_first done=%b busy=%b lo=%h expected 1 0 9", done, busy, lo);
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept busy=%b done=%b expected 1 0", busy, done);
    end
    for (int i = 8; i <= 11; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL b2b_busy2 cyc=%0d busy=%b done=%b expected 1 0", i, busy, done);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd49) begin
      n_fail++; $display("FAIL b2b_second done=%b hi=%h lo=%h expected 1 0 31", done, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    go(3'd2, 32'd100, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre busy=%b expected 1", busy);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_after cyc=%0d busy=%b done=%b expected 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_madd;
    go(3'd4, 32'd0, 32'd0, 1'b0);
    go(3'd5, 32'hFFFFFFFF, 32'd0, 1'b0);
    go(3'd6, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL madd_busy cyc=%0d busy=%b done=%b expected 1 0", i, busy, done);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || hi !== 32'd1 || lo !== 32'd0) begin
      n_fail++; $display("FAIL madd_result done=%b hi=%h lo=%h expected 1 1 0", done, hi, lo);
    end
    @(negedge clk);
`else
    for (int i = 1; i <= 6; i++) begin
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL madd_off cyc=%0d busy=%b done=%b expected 0 0", i, busy, done);
      end
      @(negedge clk);
    end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL madd_off_hilo hi=%h lo=%h expected 0 ffffffff", hi, lo);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; start = 1'b0; op = 3'd0; flush = 1'b0; a = '0; b = '0;
    test_reset;
    test_mult;
    test_div;
    test_div_overflow;
    test_mt_divzero;
    test_busy_ignore;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    test_madd;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 5, is the number of busy cycles for the multiply class (MULT, MULTU, MADD, MSUB).
REQ-002 Parameter DIV_CYCLES, default 10, is the number of busy cycles for the divide class (DIV, DIVU).
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: E-stage multiply/divide instruction is valid this cycle.
REQ-006 Port op, input, 3: operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-007 Port flush, input, 1: the E-stage instruction is being cancelled by an exception or interrupt this cycle.
REQ-008 Port a, input, 32: rs operand, already forwarded.
REQ-009 Port b, input, 32: rt operand, already forwarded.
REQ-010 Port busy, output, 1: registered; an operation is in progress.
REQ-011 Port done, output, 1: registered single-cycle pulse; HI/LO were updated by a completed operation.
REQ-012 Port hi, output, 32: HI register.
REQ-013 Port lo, output, 32: LO register.

Function
REQ-014 The block SHALL implement the states IDLE and RUN, using a 4-bit down-counter cnt.
- IDLE to RUN: at the edge where start=1, flush=0, the op is multiply or divide class, and the op is enabled.
- Load value: cnt = MUL_CYCLES-1 or DIV_CYCLES-1.
REQ-015 On entering RUN, the block SHALL latch op, a, b and the computed 64-bit result; later changes on a, b and op are ignored.
REQ-016 busy SHALL be 1 for exactly N consecutive cycles, starting the cycle after the start edge (N = MUL_CYCLES or DIV_CYCLES).
REQ-017 At the edge ending the last busy cycle (cnt==0), the block SHALL:
- write HI/LO;
- set done=1 for one cycle;
- return to IDLE.
REQ-018 The result rules SHALL be:
- MULT/MULTU: {hi,lo} = signed/unsigned a*b, 64-bit.
- DIV/DIVU: lo = quotient, hi = remainder, signed/unsigned, truncating toward zero; remainder takes the sign of the dividend.
REQ-019 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-020 DIV/DIVU with b=0 SHALL run the full DIV_CYCLES and then leave hi/lo unchanged; done is still pulsed.
REQ-021 MTHI/MTLO with start=1, flush=0 and busy=0 SHALL write a into hi/lo at that edge, with no busy and no done.
REQ-022 A start while busy=1 SHALL be ignored for every op, leaving the running operation and hi/lo unaffected.
REQ-023 start with flush=1 SHALL be ignored, with no state change.
REQ-024 flush while busy=1 SHALL NOT abort the running operation; the operation is already committed.
REQ-025 A start in the same cycle as completion (busy=1, cnt==0) SHALL be ignored; it is accepted on the following cycle.
REQ-026 done and busy SHALL never be 1 in the same cycle.

Reset
REQ-027 Asserting reset SHALL asynchronously force:
- state=IDLE, cnt=0, busy=0, done=0;
- hi=0, lo=0;
- latched operands and result cleared to 0.
REQ-028 Reset asserted mid-RUN SHALL discard the operation, and no done pulse follows after reset is released.

Configuration
REQ-029 Macro MDU_MADD_EN SHALL control the accumulate ops.
- Defined: op 6 (MADD) gives {hi,lo} += signed a*b; op 7 (MSUB) gives {hi,lo} -= signed a*b.
- Both are modulo 2^64, use MUL_CYCLES latency, and read {hi,lo} at completion.
- Not defined: op 6 and op 7 are ignored (no busy, no done, hi/lo unchanged).

Verification
REQ-030 Scenario: MULT a=0xFFFFFFFE, b=3.
- busy high for cycles 1..5;
- done at cycle 6;
- hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 Scenario: DIV a=-7, b=2.
- busy for 10 cycles;
- then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 Scenario: DIVU a=5, b=0 with hi=0x11, lo=0x22 beforehand.
- done after 10 cycles;
- hi=0x11, lo=0x22.
REQ-033 Scenario: MULTU 2*3, then MTLO a=9 issued at busy cycle 2.
- MTLO is ignored;
- final hi=0, lo=6.
REQ-034 Scenario: start MULT with flush=1.
- busy stays 0 and hi/lo are unchanged.
- Then reset at busy cycle 3 of a DIV: all outputs 0 immediately, and no done afterwards.
REQ-035 Scenario (MDU_MADD_EN defined): hi=0, lo=0xFFFFFFFF, then MADD 1*1.
- hi=1, lo=0 after 5 cycles.
- Without the macro: busy stays 0 and hi/lo are unchanged.
